// File: rtl/uram_pkg.sv
// Shared constants, state type and sizing helper for the UltraRAM model.
package uram_pkg;

  localparam int SEG_W      = 72;
  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 4;

  typedef enum logic {CLEAR, RUN} uram_state_t;

  function automatic int nsegs(input int width);
    return (width + SEG_W - 1) / SEG_W;
  endfunction

endpackage

// File: rtl/uram_model_rw_if.sv
// Write/read port bundle of the UltraRAM model; master = client, slave = RAM.
interface uram_model_rw_if
  import uram_pkg::*;
#(
  parameter int WIDTH  = 3072,
  parameter int ADDR_W = 12,
  parameter int SEGS   = nsegs(WIDTH)
);
  logic              init_done;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [SEGS-1:0]   wr_seg_en;
  logic [WIDTH-1:0]  wr_data;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_valid;
  logic [WIDTH-1:0]  rd_data;

  modport master (
    input  init_done, rd_valid, rd_data,
    output wr_en, wr_addr, wr_seg_en, wr_data, rd_en, rd_addr
  );

  modport slave (
    output init_done, rd_valid, rd_data,
    input  wr_en, wr_addr, wr_seg_en, wr_data, rd_en, rd_addr
  );
endinterface

// File: rtl/uram_rd_pipe.sv
// STAGES-deep {valid, data} shift register; data stages only load on valid,
// so the output word holds its last value between reads.
module uram_rd_pipe #(
  parameter int WIDTH  = 3072,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_vld_i,
  input  logic [WIDTH-1:0] in_dat_i,
  output logic             out_vld_o,
  output logic [WIDTH-1:0] out_dat_o
);

  logic [STAGES:1]            vld_pipe;
  logic [STAGES:1][WIDTH-1:0] dat_pipe;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe <= '0;
      dat_pipe <= '0;
    end else begin
      vld_pipe[1] <= in_vld_i;
      if (in_vld_i) dat_pipe[1] <= in_dat_i;
      for (int i = 2; i <= STAGES; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        if (vld_pipe[i-1]) dat_pipe[i] <= dat_pipe[i-1];
      end
    end
  end

  assign out_vld_o = vld_pipe[STAGES];
  assign out_dat_o = dat_pipe[STAGES];

endmodule

// File: rtl/uram_model_rw.sv
// Behavioural UltraRAM: segmented write port, pipelined read port, post-reset
// clear sweep. Optional URAM_SEQ_TAG_EN stamps a read sequence tag in the top bits.
module uram_model_rw
  import uram_pkg::*;
#(
  parameter int WIDTH  = 3072,
  parameter int DEPTH  = 4096,
  parameter int ADDR_W = 12,
  parameter int RD_LAT = 2,
  parameter int TAG_W  = 2
) (
  input  logic             clk,
  input  logic             rst,
  uram_model_rw_if.slave   bus
);

  localparam int SEGS = nsegs(WIDTH);

  if (RD_LAT < RD_LAT_MIN || RD_LAT > RD_LAT_MAX) begin : g_bad_lat
    $error("uram_model_rw: RD_LAT must be within 1..4");
  end
  if (DEPTH < 1 || DEPTH > (1 << ADDR_W)) begin : g_bad_depth
    $error("uram_model_rw: DEPTH must be 1..2**ADDR_W");
  end
  if (TAG_W < 1 || TAG_W > WIDTH) begin : g_bad_tag
    $error("uram_model_rw: TAG_W must be 1..WIDTH");
  end

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return 32'(a) < DEPTH;
  endfunction

  // Clear sweep FSM: RUN is terminal until the next reset
  uram_state_t       state_q;
  logic [ADDR_W-1:0] clr_addr_q;
  logic              init_done_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= CLEAR;
      clr_addr_q  <= '0;
      init_done_q <= 1'b0;
    end else begin
      case (state_q)
        CLEAR: begin
          if (clr_addr_q == ADDR_W'(DEPTH - 1)) begin
            state_q     <= RUN;
            init_done_q <= 1'b1;
          end else begin
            clr_addr_q <= clr_addr_q + 1'b1;
          end
        end
        RUN:     state_q <= RUN;
        default: state_q <= CLEAR;
      endcase
    end
  end

  assign bus.init_done = init_done_q;

  logic wr_ok, rd_ok;
  assign wr_ok = init_done_q & bus.wr_en & in_range(bus.wr_addr);
  assign rd_ok = init_done_q & bus.rd_en;

  // Segment enables expanded to a bit mask; the last segment is clipped to WIDTH
  logic [WIDTH-1:0] wmask;
  for (genvar b = 0; b < WIDTH; b++) begin : g_mask
    assign wmask[b] = bus.wr_seg_en[b / SEG_W];
  end

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (state_q == CLEAR)
      mem[clr_addr_q] <= '0;
    else if (wr_ok)
      mem[bus.wr_addr] <= (mem[bus.wr_addr] & ~wmask) | (bus.wr_data & wmask);
  end

  // Storage read stage; non-blocking write above makes same-address access read-first
  logic [WIDTH-1:0] rd_word, rd_stage;
  assign rd_word = in_range(bus.rd_addr) ? mem[bus.rd_addr] : '0;

`ifdef URAM_SEQ_TAG_EN
  logic [TAG_W-1:0] tag_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)        tag_q <= '0;
    else if (rd_ok) tag_q <= tag_q + 1'b1;
  end

  always_comb begin
    rd_stage                     = rd_word;
    rd_stage[WIDTH-1 -: TAG_W]   = tag_q;
  end
`else
  assign rd_stage = rd_word;
`endif

  uram_rd_pipe #(
    .WIDTH  (WIDTH),
    .STAGES (RD_LAT)
  ) u_rd_pipe (
    .clk       (clk),
    .rst       (rst),
    .in_vld_i  (rd_ok),
    .in_dat_i  (rd_stage),
    .out_vld_o (bus.rd_valid),
    .out_dat_o (bus.rd_data)
  );

endmodule

// File: tb/tb_uram_model_rw.sv
// Directed scoreboard bench for uram_model_rw (WIDTH=160, DEPTH=10, RD_LAT=3).
module tb_uram_model_rw;

  localparam int W = 160, D = 10, A = 4, L = 3, T = 2, S = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uram_model_rw_if #(.WIDTH(W), .ADDR_W(A)) bus ();

  uram_model_rw #(
    .WIDTH(W), .DEPTH(D), .ADDR_W(A), .RD_LAT(L), .TAG_W(T)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [W-1:0] data;
    int           due;
    string        nm;
  } exp_t;

  exp_t         sb[$];
  exp_t         e;
  logic [W-1:0] model [D];
  logic [W-1:0] last_m = '0;
  logic [T-1:0] tag_m  = '0;
  int checks = 0, errors = 0, cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [W-1:0] seg_mask(input logic [S-1:0] seg);
    logic [W-1:0] m;
    for (int b = 0; b < W; b++) m[b] = seg[b / 72];
    return m;
  endfunction

  // Output monitor: pops on every rd_valid, otherwise checks that rd_data holds
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.rd_valid) begin
        checks++;
        assert (sb.size() != 0) else begin
          errors++; $error("FAIL stray_valid got rd_valid=1 want 0 at cyc %0d", cyc);
        end
        if (sb.size() != 0) begin
          e = sb.pop_front();
          checks += 2;
          assert (bus.rd_data === e.data) else begin
            errors++; $error("FAIL %s data got %h want %h", e.nm, bus.rd_data, e.data);
          end
          assert (cyc === e.due) else begin
            errors++; $error("FAIL %s latency got cyc %0d want %0d", e.nm, cyc, e.due);
          end
          last_m = e.data;
        end
      end else begin
        checks++;
        assert (bus.rd_data === last_m) else begin
          errors++; $error("FAIL hold got %h want %h", bus.rd_data, last_m);
        end
      end
    end
  end

  task automatic drive(input bit we, input int wa, input logic [S-1:0] seg,
                       input logic [W-1:0] wd, input bit re, input int ra, input string nm);
    logic [W-1:0] d, m;
    @(posedge clk); #1;
    bus.wr_en = we; bus.wr_addr = A'(wa); bus.wr_seg_en = seg; bus.wr_data = wd;
    bus.rd_en = re; bus.rd_addr = A'(ra);
    if (re) begin
      d = (ra < D) ? model[ra] : '0;
`ifdef URAM_SEQ_TAG_EN
      d[W-1 -: T] = tag_m;
      tag_m++;
`endif
      sb.push_back('{d, cyc + L, nm});
    end
    if (we && wa < D) begin
      m = seg_mask(seg);
      model[wa] = (model[wa] & ~m) | (wd & m);
    end
  endtask

  task automatic rd(input int ra, input string nm);
    drive(1'b0, 0, '0, '0, 1'b1, ra, nm);
  endtask

  task automatic drain();
    int n = 0;
    @(posedge clk); #1;
    bus.wr_en = 1'b0; bus.rd_en = 1'b0;
    while (sb.size() != 0 && n < 20) begin
      @(posedge clk); n++;
    end
    checks++;
    assert (sb.size() == 0) else begin
      errors++; $error("FAIL drain_timeout got %0d pending want 0", sb.size());
    end
    repeat (3) @(posedge clk);
  endtask

  // Reset, then run the clear sweep while hammering both ports (must be ignored)
  task automatic reset_and_init();
    @(posedge clk); #1;
    rst = 1'b1;
    bus.wr_en = 1'b0; bus.rd_en = 1'b0;
    sb.delete(); last_m = '0; tag_m = '0;
    for (int i = 0; i < D; i++) model[i] = '0;
    @(posedge clk); #1;
    checks += 3;
    assert (bus.init_done === 1'b0) else begin
      errors++; $error("FAIL rst_init_done got %b want 0", bus.init_done);
    end
    assert (bus.rd_valid === 1'b0) else begin
      errors++; $error("FAIL rst_rd_valid got %b want 0", bus.rd_valid);
    end
    assert (bus.rd_data === '0) else begin
      errors++; $error("FAIL rst_rd_data got %h want 0", bus.rd_data);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    bus.rd_en = 1'b1; bus.rd_addr = '0;
    bus.wr_en = 1'b1; bus.wr_addr = A'(2); bus.wr_seg_en = '1; bus.wr_data = '1;
    for (int k = 1; k <= D; k++) begin
      @(posedge clk); #1;
      checks++;
      assert (bus.init_done === 1'(k == D)) else begin
        errors++; $error("FAIL init_done_k%0d got %b want %b", k, bus.init_done, k == D);
      end
      bus.rd_addr = A'(k % D);
      if (k == D) begin
        bus.rd_en = 1'b0; bus.wr_en = 1'b0;
      end
    end
  endtask

  initial begin
    bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_seg_en = '0; bus.wr_data = '0;
    bus.rd_en = 1'b0; bus.rd_addr = '0;

    reset_and_init();
    for (int a = 0; a < D; a++) rd(a, "clr_rd");

    drive(1'b1, 3, '1, {20{8'hA5}}, 1'b0, 0, "wr3");
    rd(3, "rd3_a5");
    rd(3, "b2b_3"); rd(4, "b2b_4"); rd(3, "b2b_3b");

    drive(1'b1, 5, 3'b010, '1, 1'b0, 0, "wr5");
    rd(5, "seg1_only");
    drive(1'b1, 6, 3'b100, '1, 1'b0, 0, "wr6");
    rd(6, "seg2_clip");
    drive(1'b1, 3, 3'b001, '0, 1'b0, 0, "wr3_lo");
    rd(3, "seg0_over");

    drive(1'b1, 7, '1, W'(1), 1'b1, 7, "rw_same_old");
    rd(7, "rw_same_new");

    drive(1'b1, 12, '1, '1, 1'b0, 0, "wr_oor");
    rd(12, "rd_oor");
    for (int a = 0; a < D; a++) rd(a, "post_oor");
    drain();

    rd(3, "inflight_a");
    rd(6, "inflight_b");
    reset_and_init();
    rd(3, "post_rst_3"); rd(6, "post_rst_6"); rd(2, "post_rst_2");
    drain();

    for (int i = 0; i < 5; i++) rd(1, "tag_seq");
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
